// File: rtl/rv32i_types.sv
// Shared RV32I types: the machine word and the branch-recovery FSM states.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_WAIT_FETCH,
    BR_REDIRECT
  } br_rec_state_t;

  localparam rv32i_word INSTR_BYTES = 32'd4;

  // Correct-path PC once the real direction is known; the add wraps modulo 2^32.
  function automatic rv32i_word recovery_pc(input logic taken,
                                            input rv32i_word pc,
                                            input rv32i_word tgt);
    return taken ? tgt : pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/branch_recovery_ctrl_perf_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module perf_counter
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  output rv32i_word count
);

  rv32i_word count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Flush / drain-fetch / redirect sequencer for resolved control flow, plus
// the one-cycle predictor update strobe and branch performance counters.
module branch_recovery_ctrl
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      ex_valid,
  input  logic      ex_is_branch,
  input  logic      ex_is_jump,
  input  logic      misprediction,
  input  logic      br_en,
  input  rv32i_word ex_pc,
  input  rv32i_word target,
  input  logic      pipe_stall,
  input  logic      icache_busy,
  output logic      flush_ifid,
  output logic      flush_idex,
  output logic      hold_front,
  output logic      pc_redirect,
  output rv32i_word redirect_pc,
  output logic      pred_update_valid,
  output rv32i_word pred_update_pc,
  output rv32i_word pred_update_target,
  output logic      pred_update_taken,
  output rv32i_word perf_branches,
  output rv32i_word perf_mispredicts
);

  br_rec_state_t state_reg, state_next;

  rv32i_word redirect_pc_reg;
  logic      upd_valid_reg;
  rv32i_word upd_pc_reg;
  rv32i_word upd_target_reg;
  logic      upd_taken_reg;

  logic resolve_evt;
  logic mispredict_evt;
  logic actual_taken;

  // Anything reaching EX while a recovery is in flight is wrong-path and dropped.
  assign resolve_evt    = ex_valid && (ex_is_branch || ex_is_jump) && !pipe_stall
                          && (state_reg == BR_IDLE);
  assign mispredict_evt = resolve_evt && misprediction;
  assign actual_taken   = br_en || ex_is_jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BR_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    hold_front  = 1'b0;
    pc_redirect = 1'b0;
    unique case (state_reg)
      BR_IDLE: begin
        if (mispredict_evt) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_next = icache_busy ? BR_WAIT_FETCH : BR_REDIRECT;
        end
      end
      BR_WAIT_FETCH: begin
        // Keep killing IF/ID so a late wrong-path fetch never reaches decode.
        hold_front = 1'b1;
        flush_ifid = 1'b1;
        if (!icache_busy) begin
          state_next = BR_REDIRECT;
        end
      end
      BR_REDIRECT: begin
        pc_redirect = 1'b1;
        flush_ifid  = 1'b1;
        if (!pipe_stall) begin
          state_next = BR_IDLE;
        end
      end
      default: begin
        state_next = BR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_reg <= '0;
    end else if (mispredict_evt) begin
      redirect_pc_reg <= recovery_pc(actual_taken, ex_pc, target);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_reg  <= 1'b0;
      upd_pc_reg     <= '0;
      upd_target_reg <= '0;
      upd_taken_reg  <= 1'b0;
    end else begin
      upd_valid_reg <= resolve_evt;
      if (resolve_evt) begin
        upd_pc_reg     <= ex_pc;
        upd_target_reg <= target;
        upd_taken_reg  <= actual_taken;
      end
    end
  end

  assign redirect_pc        = redirect_pc_reg;
  assign pred_update_valid  = upd_valid_reg;
  assign pred_update_pc     = upd_pc_reg;
  assign pred_update_target = upd_target_reg;
  assign pred_update_taken  = upd_taken_reg;

  perf_counter u_perf_branches (
    .clk   (clk),
    .rst   (rst),
    .inc   (resolve_evt),
    .count (perf_branches)
  );

  perf_counter u_perf_mispredicts (
    .clk   (clk),
    .rst   (rst),
    .inc   (mispredict_evt),
    .count (perf_mispredicts)
  );

endmodule
